// File: rtl/des_sbox_bank.sv
// DES substitution stage: eight S-box lookups on a 48-bit keyed word,
// LANES boxes per cycle, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// BUSY  | one group of LANES lookups per cycle, NPASS cycles total
// DONE  | result presented on dout, waiting for out_ready
module des_sbox_bank #(
  parameter int LANES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout
);

  localparam int NPASS = 8 / LANES;
  localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [CW-1:0] LAST_PASS = CW'(NPASS - 1);

  // S1..S8, each 4 rows x 16 columns, entry (box,row,col) at nibble box*64+row*16+col from the top
  localparam logic [2047:0] SBOX_ROM = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] b);
    logic [8:0] idx;
    idx = {box, b[5], b[0], b[4:1]};
    return SBOX_ROM[11'd2047 - {idx, 2'b00} -: 4];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [47:0]       in_sr;
  logic [31:0]       res_sr;
  logic [CW-1:0]     pass_cnt;
  logic [2:0]        box_base;
  logic [4*LANES-1:0] lane_res;
  logic [31:0]       res_next;

  assign box_base = 3'(int'(pass_cnt) * LANES);

  always_comb begin
    lane_res = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_res[4*(LANES-1-l) +: 4] = sbox(box_base + 3'(l), in_sr[47-6*l -: 6]);
    end
  end

  assign res_next = (res_sr << (4*LANES)) | 32'(lane_res);
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_sr     <= '0;
      res_sr    <= '0;
      pass_cnt  <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_sr    <= din;
            pass_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          in_sr  <= in_sr << (6*LANES);
          res_sr <= res_next;
          if (pass_cnt == LAST_PASS) begin
            pass_cnt  <= '0;
            dout      <= res_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            pass_cnt <= pass_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              in_sr    <= din;
              pass_cnt <= '0;
              state    <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_sbox_bank.sv
// Bench for des_sbox_bank: one instance per LANES value (1,2,4,8), each
// checked against a table-driven DES S-box model.
module tb_des_sbox_bank;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       in_valid, in_ready, out_valid, out_ready;
  logic [3:0][47:0] din;
  logic [3:0][31:0] dout;
  int checks = 0;
  int errors = 0;

  int sbt [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_bank #(.LANES(1 << g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .din      (din[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .dout     (dout[g])
    );
  end

  function automatic logic [31:0] ref_sbox(input logic [47:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      int b, row, col;
      b   = int'((d >> (6 * (7 - k))) & 48'h3F);
      row = ((b >> 5) & 1) * 2 + (b & 1);
      col = (b >> 1) & 15;
      r   = (r << 4) | 32'(sbt[k][row * 16 + col]);
    end
    return r;
  endfunction

  function automatic string tagf(input int i, input string s);
    return $sformatf("L%0d %s", 1 << i, s);
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One word with out_ready high from an idle block; n counts edges after acceptance.
  task automatic run_word(input int i, input logic [47:0] d, input logic [31:0] exp, input string tag);
    int n;
    @(negedge clk);
    chk(tagf(i, {tag, " in_ready"}), 64'(in_ready[i]), 64'd1);
    din[i] = d;
    in_valid[i] = 1'b1;
    out_ready[i] = 1'b1;
    @(negedge clk);
    in_valid[i] = 1'b0;
    n = 0;
    while (!out_valid[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tagf(i, {tag, " latency"}), 64'(n), 64'(8 >> i));
    chk(tagf(i, {tag, " dout"}), 64'(dout[i]), 64'(exp));
    @(negedge clk);
    chk(tagf(i, {tag, " valid pulse"}), 64'(out_valid[i]), 64'd0);
  endtask

  task automatic backpressure(input int i);
    logic [47:0] a, c;
    int n;
    a = rand48();
    c = rand48();
    @(negedge clk);
    din[i] = a;
    in_valid[i] = 1'b1;
    out_ready[i] = 1'b0;
    @(negedge clk);
    in_valid[i] = 1'b0;
    n = 0;
    while (!out_valid[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tagf(i, "bp latency"), 64'(n), 64'(8 >> i));
    for (int c2 = 0; c2 < 5; c2++) begin
      chk(tagf(i, "bp dout hold"), 64'(dout[i]), 64'(ref_sbox(a)));
      chk(tagf(i, "bp in_ready low"), 64'(in_ready[i]), 64'd0);
      chk(tagf(i, "bp valid hold"), 64'(out_valid[i]), 64'd1);
      din[i] = rand48();
      in_valid[i] = c2[0];
      @(negedge clk);
    end
    chk(tagf(i, "bp dout final"), 64'(dout[i]), 64'(ref_sbox(a)));
    din[i] = c;
    in_valid[i] = 1'b1;
    out_ready[i] = 1'b1;
    #1;
    chk(tagf(i, "bp release in_ready"), 64'(in_ready[i]), 64'd1);
    @(negedge clk);
    in_valid[i] = 1'b0;
    chk(tagf(i, "bp release valid drop"), 64'(out_valid[i]), 64'd0);
    n = 0;
    while (!out_valid[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tagf(i, "bp next latency"), 64'(n), 64'(8 >> i));
    chk(tagf(i, "bp next dout"), 64'(dout[i]), 64'(ref_sbox(c)));
    @(negedge clk);
  endtask

  task automatic stream(input int i);
    logic [47:0] w [16];
    logic [31:0] q [$];
    int sent, got, last;
    sent = 0;
    got = 0;
    last = -1;
    for (int j = 0; j < 16; j++) w[j] = rand48();
    out_ready[i] = 1'b1;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      if (out_valid[i]) begin
        chk(tagf(i, "stream pending"), 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) chk(tagf(i, "stream dout"), 64'(dout[i]), 64'(q.pop_front()));
        if (last >= 0) chk(tagf(i, "stream spacing"), 64'(cyc - last), 64'((8 >> i) + 1));
        last = cyc;
        got++;
      end
      if (sent < 16) begin
        din[i] = w[sent];
        in_valid[i] = 1'b1;
        if (in_ready[i]) begin
          q.push_back(ref_sbox(w[sent]));
          sent++;
        end
      end else begin
        in_valid[i] = 1'b0;
      end
    end
    in_valid[i] = 1'b0;
    chk(tagf(i, "stream count"), 64'(got), 64'd16);
    @(negedge clk);
  endtask

  task automatic reset_mid_busy();
    logic [47:0] d;
    @(negedge clk);
    din[0] = rand48();
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      in_valid[0] = 1'b0;
    end
    chk("L1 busy before reset", 64'(in_ready[0]), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("L1 reset in_ready", 64'(in_ready[0]), 64'd1);
    chk("L1 reset out_valid", 64'(out_valid[0]), 64'd0);
    chk("L1 reset dout", 64'(dout[0]), 64'd0);
    #1;
    rst_n = 1'b1;
    d = rand48();
    run_word(0, d, ref_sbox(d), "after reset");
  endtask

  initial begin
    in_valid = '0;
    out_ready = '0;
    din = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk(tagf(i, "rst in_ready"), 64'(in_ready[i]), 64'd1);
      chk(tagf(i, "rst out_valid"), 64'(out_valid[i]), 64'd0);
      chk(tagf(i, "rst dout"), 64'(dout[i]), 64'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_word(i, 48'h000000000000, 32'hEFA72C4D, "zeros");
      run_word(i, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "ones");
      run_word(i, 48'h6117BA866527, 32'h5C82B597, "vector");
    end

    for (int i = 0; i < 4; i++) backpressure(i);
    for (int i = 0; i < 4; i++) stream(i);
    reset_mid_busy();

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) begin
        for (int v = 0; v < 64; v++) begin
          logic [47:0] d;
          d = 48'(v) << (6 * (7 - k));
          run_word(i, d, ref_sbox(d), $sformatf("sweep S%0d v%0d", k + 1, v));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
